pwm_control_sysid_checker: RTL and testbench



---
 rtl/pwm_control_sysid_checker_pkg.sv | 8 +
 rtl/pwm_control_sysid_checker_if.sv | 9 +
 rtl/pwm_control_sysid_checker_wait_timer.sv | 19 +
 rtl/pwm_control_sysid_checker.sv | 113 +++++++++++
 tb/tb_pwm_control_sysid_checker.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_control_sysid_checker_pkg.sv
// pwm_control_pkg: shared FSM states and sysid constants for the PWM control core.
package pwm_control_pkg;
    typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, EVAL} state_e;
    localparam logic [31:0] DEF_EXPECTED_ID = 32'h2013_1107;
    localparam logic [31:0] DEF_EXPECTED_TS = 32'h527A_E51F;
    localparam logic        SYSID_ADDR_ID   = 1'b0;
    localparam logic        SYSID_ADDR_TS   = 1'b1;
endpackage

// File: rtl/pwm_control_sysid_checker_if.sv
// pwm_control_sysid_checker_if: Avalon-MM read-only link between the checker and the sysid slave.
interface pwm_control_sysid_checker_if;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    modport master (output avm_address, avm_read, input avm_readdata, avm_waitrequest);
    modport slave  (input avm_address, avm_read, output avm_readdata, avm_waitrequest);
endinterface

// File: rtl/pwm_control_sysid_checker_wait_timer.sv
// pwm_control_wait_timer: saturating 16-bit stall counter; expired once it reaches TIMEOUT_CYCLES.
module pwm_control_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [15:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? '0 : (en && cnt_q != '1) ? cnt_q + 16'd1 : cnt_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
    // A zero limit means "wait forever".
    assign expired = (TIMEOUT_CYCLES != 0) && (cnt_q == 16'(TIMEOUT_CYCLES));
endmodule

// File: rtl/pwm_control_sysid_checker.sv
// pwm_control_sysid_checker: reads the sysid ID and timestamp words, compares them against
// build-time values with retries and a per-read stall timeout, and keeps a sticky verdict.
module pwm_control_sysid_checker
    import pwm_control_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = DEF_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = DEF_EXPECTED_TS,
    parameter bit          CHECK_TS       = 1'b1,
    parameter int unsigned RETRIES        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    pwm_control_sysid_checker_if.master avm,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);
    state_e      state_q, state_d;
    logic [3:0]  retry_q, retry_d;
    logic        auto_q, done_q, done_d, pass_q, pass_d, tmo_q, tmo_d;
    logic [31:0] id_q, id_d, ts_q, ts_d;
    logic        reading, stall, expired, abort, match;

    assign reading = (state_q == RD_ID) || (state_q == RD_TS);
    assign stall   = avm.avm_waitrequest;
    assign abort   = reading && stall && expired;
    assign match   = (id_q == EXPECTED_ID) && (!CHECK_TS || ts_q == EXPECTED_TS);

    pwm_control_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clr    (!reading || (state_q == RD_ID && !stall)),
        .en     (reading && stall),
        .expired(expired)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        tmo_d   = tmo_q;
        id_d    = id_q;
        ts_d    = ts_q;
        case (state_q)
            IDLE: if (start || auto_q) begin
                state_d = RD_ID;
                retry_d = 4'(RETRIES);
            end
            RD_ID: if (!stall) begin
                id_d    = avm.avm_readdata;
                state_d = RD_TS;
            end
            RD_TS: if (!stall) begin
                ts_d    = avm.avm_readdata;
                state_d = EVAL;
            end
            EVAL: if (!match && retry_q != 4'd0) begin
                retry_d = retry_q - 4'd1;
                state_d = RD_ID;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
                pass_d  = match;
                tmo_d   = 1'b0;
            end
        endcase
        // A stalled read that hits the limit ends the whole sequence without using a retry.
        if (abort) begin
            state_d = IDLE;
            done_d  = 1'b1;
            pass_d  = 1'b0;
            tmo_d   = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            retry_q <= '0;
            auto_q  <= AUTO_START;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            tmo_q   <= 1'b0;
            id_q    <= '0;
            ts_q    <= '0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            auto_q  <= 1'b0;
            done_q  <= done_d;
            pass_q  <= pass_d;
            tmo_q   <= tmo_d;
            id_q    <= id_d;
            ts_q    <= ts_d;
        end
    end

    assign avm.avm_read    = reading;
    assign avm.avm_address = (state_q == RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    assign busy            = (state_q != IDLE);
    assign done            = done_q;
    assign pass            = pass_q;
    assign timeout         = tmo_q;
    assign id_value        = id_q;
    assign ts_value        = ts_q;
endmodule

// File: tb/tb_pwm_control_sysid_checker.sv
// tb_pwm_control_sysid_checker: two configurations driven by shared random and directed stimulus,
// each checked every cycle against a transaction-level model, plus literal latency pins.
module tb_pwm_control_sysid_checker;
    localparam logic [31:0] EID = 32'h2013_1107;
    localparam logic [31:0] ETS = 32'h527A_E51F;

    logic        clk = 1'b0, rst = 1'b0, st = 1'b0, wr = 1'b0;
    logic [31:0] id_word = EID, ts_word = ETS;
    int          cyc = 0, checks = 0, errors = 0, dca = -100, dcb = -100;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input int u, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL u%0d %s got %h want %h (cycle %0d)", u, nm, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_u
        localparam bit CK   = (g == 0);
        localparam int RET  = (g == 0) ? 2 : 0;
        localparam int TMO  = (g == 0) ? 4 : 0;
        localparam bit AUTO = (g == 0);

        pwm_control_sysid_checker_if bus ();
        logic        busy, done, pass, timeout;
        logic [31:0] idv, tsv;
        assign bus.avm_waitrequest = wr;
        assign bus.avm_readdata    = bus.avm_address ? ts_word : id_word;

        pwm_control_sysid_checker #(
            .CHECK_TS(CK), .RETRIES(RET), .TIMEOUT_CYCLES(TMO), .AUTO_START(AUTO)
        ) dut (
            .clock(clk), .reset(rst), .start(st), .avm(bus),
            .busy(busy), .done(done), .pass(pass), .timeout(timeout),
            .id_value(idv), .ts_value(tsv)
        );

        // e_*: expected outputs this cycle; n_*: what the sequence has decided for the next cycle.
        logic        e_busy = 0, e_read = 0, e_addr = 0, e_done = 0, e_pass = 0, e_to = 0;
        logic        n_busy = 0, n_read = 0, n_addr = 0, n_done = 0, n_pass = 0, n_to = 0;
        logic [31:0] e_id = 0, e_ts = 0, n_id = 0, n_ts = 0;

        task automatic tick(output bit ab);
            @(posedge clk);
            #2;
            ab = rst;
            if (ab) begin
                {n_busy, n_read, n_addr, n_done, n_pass, n_to} = '0;
                n_id = '0;
                n_ts = '0;
            end
            {e_busy, e_read, e_addr, e_done, e_pass, e_to} = {n_busy, n_read, n_addr, n_done, n_pass, n_to};
            e_id   = n_id;
            e_ts   = n_ts;
            n_done = 1'b0;
        endtask

        task automatic rd(input bit a, output logic [31:0] w, output bit to, output bit ab);
            int n = 0;
            to = 1'b0;
            w  = '0;
            forever begin
                tick(ab);
                if (ab) return;
                if (!wr) begin
                    w = a ? ts_word : id_word;
                    return;
                end
                if (TMO != 0 && n == TMO) begin
                    to = 1'b1;
                    return;
                end
                n++;
            end
        endtask

        initial begin
            bit ab, to, ok, go;
            int tries;
            logic [31:0] w;
            ab = 1'b1;
            forever begin
                while (ab) tick(ab);
                go = AUTO;
                while (!ab) begin
                    if (go || st) begin
                        go = 1'b0;
                        tries = RET;
                        ok = 1'b0;
                        to = 1'b0;
                        forever begin
                            n_busy = 1'b1; n_read = 1'b1; n_addr = 1'b0;
                            rd(1'b0, w, to, ab);
                            if (ab || to) break;
                            n_id = w; n_addr = 1'b1;
                            rd(1'b1, w, to, ab);
                            if (ab || to) break;
                            n_ts = w; n_read = 1'b0; n_addr = 1'b0;
                            tick(ab);
                            if (ab) break;
                            ok = (e_id == EID) && (!CK || e_ts == ETS);
                            if (ok || tries == 0) break;
                            tries--;
                        end
                        if (!ab) begin
                            n_busy = 1'b0; n_read = 1'b0; n_addr = 1'b0;
                            n_done = 1'b1; n_pass = ok && !to; n_to = to;
                        end
                    end
                    if (!ab) tick(ab);
                end
            end
        end

        initial forever begin
            @(negedge clk);
            cmp(g, "busy",     32'(busy),            rst ? 32'd0 : 32'(e_busy));
            cmp(g, "avm_read", 32'(bus.avm_read),    rst ? 32'd0 : 32'(e_read));
            cmp(g, "avm_addr", 32'(bus.avm_address), rst ? 32'd0 : 32'(e_addr));
            cmp(g, "done",     32'(done),            rst ? 32'd0 : 32'(e_done));
            cmp(g, "pass",     32'(pass),            rst ? 32'd0 : 32'(e_pass));
            cmp(g, "timeout",  32'(timeout),         rst ? 32'd0 : 32'(e_to));
            cmp(g, "id_value", idv,                  rst ? 32'd0 : e_id);
            cmp(g, "ts_value", tsv,                  rst ? 32'd0 : e_ts);
        end
    end

    initial forever begin
        @(negedge clk);
        if (g_u[0].done) dca = cyc;
        if (g_u[1].done) dcb = cyc;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic launch(output int k);
        k  = cyc;
        st = 1'b1;
        step(1);
        st = 1'b0;
    endtask

    task automatic pin(input string nm, input int k, input int la, input bit pa, input int lb, input bit pb);
        step(14);
        cmp(0, {nm, "_done_cycle"}, 32'(dca), 32'(k + la));
        cmp(0, {nm, "_pass"}, 32'(g_u[0].pass), 32'(pa));
        if (lb >= 0) begin
            cmp(1, {nm, "_done_cycle"}, 32'(dcb), 32'(k + lb));
            cmp(1, {nm, "_pass"}, 32'(g_u[1].pass), 32'(pb));
        end
    endtask

    initial begin
        int k, m, t6;
        #1 rst = 1'b1;
        step(3);
        rst = 1'b0;
        k = cyc;
        pin("auto", k, 4, 1'b1, -1, 1'b0);

        launch(k);
        pin("match", k, 4, 1'b1, 4, 1'b1);
        cmp(0, "match_id_value", g_u[0].idv, 32'h2013_1107);

        id_word = 32'hDEAD_BEEF;
        launch(k);
        pin("bad_id", k, 10, 1'b0, 4, 1'b0);

        launch(k);
        step(1);
        id_word = EID;
        pin("retry_ok", k, 7, 1'b1, 4, 1'b0);

        ts_word = 32'h0;
        launch(k);
        pin("bad_ts", k, 10, 1'b0, 4, 1'b1);
        ts_word = ETS;

        wr = 1'b1;
        launch(k);
        step(1);
        st = 1'b1;
        step(1);
        st = 1'b0;
        step(10);
        t6 = k + 6;
        cmp(0, "tmo_done_cycle", 32'(dca), 32'(t6));
        cmp(0, "tmo_timeout", 32'(g_u[0].timeout), 32'd1);
        cmp(0, "tmo_pass", 32'(g_u[0].pass), 32'd0);
        cmp(0, "tmo_read_low", 32'(g_u[0].bus.avm_read), 32'd0);
        cmp(0, "tmo_id_kept", g_u[0].idv, 32'h2013_1107);
        cmp(0, "tmo_not_busy", 32'(g_u[0].busy), 32'd0);
        m  = cyc;
        wr = 1'b0;
        step(6);
        cmp(1, "stall_done_cycle", 32'(dcb), 32'(m + 3));
        cmp(1, "stall_pass", 32'(g_u[1].pass), 32'd1);

        launch(k);
        step(1);
        #2 rst = 1'b1;
        #1;
        cmp(0, "rst_read_low", 32'(g_u[0].bus.avm_read), 32'd0);
        cmp(0, "rst_busy_low", 32'(g_u[0].busy), 32'd0);
        step(2);
        rst = 1'b0;
        m = cyc;
        cmp(0, "rst_no_done", 32'(dca), 32'(t6));
        step(2);
        st = 1'b1;
        step(1);
        st = 1'b0;
        step(12);
        cmp(0, "rst_auto_done_cycle", 32'(dca), 32'(m + 4));
        cmp(0, "rst_auto_pass", 32'(g_u[0].pass), 32'd1);
        cmp(1, "rst_start_done_cycle", 32'(dcb), 32'(m + 6));

        repeat (3000) begin
            wr      = ($urandom_range(0, 99) < 30);
            st      = ($urandom_range(0, 15) == 0);
            id_word = ($urandom_range(0, 4) == 0) ? $urandom : EID;
            ts_word = ($urandom_range(0, 4) == 0) ? $urandom : ETS;
            step(1);
        end
        wr = 1'b0;
        st = 1'b0;
        step(40);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
